mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_resp_pkg.sv | 15 +
 rtl/mem_bank.sv | 32 +++
 rtl/mem_responder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder: the rw command encodings and the
// responder FSM state type.
package mem_resp_pkg;

    localparam logic [1:0] RW_IDLE  = 2'd0;
    localparam logic [1:0] RW_READ  = 2'd1;
    localparam logic [1:0] RW_WRITE = 2'd2;
    localparam logic [1:0] RW_RSVD  = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

endpackage

// File: rtl/mem_bank.sv
// Single-port DEPTH x DATA_LEN storage bank with a synchronous write and a registered read.
// The array has no reset, so its contents survive a responder reset.
module mem_bank
    import mem_resp_pkg::*;
#(
    parameter int ADDR_LEN = 10,
    parameter int DATA_LEN = 1,
    parameter int DEPTH    = 784
) (
    input  logic                clk,
    input  logic                we,
    input  logic                re,
    input  logic [ADDR_LEN-1:0] addr,
    input  logic [DATA_LEN-1:0] wdata,
    output logic [DATA_LEN-1:0] rdata
);

    logic [DATA_LEN-1:0] mem_q [DEPTH];
    logic [DATA_LEN-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Bus-attached memory responder: decodes rw/sel/addr, drives read data one cycle later,
// flags protocol errors. Define MEM_RESP_ACCESS_CNT_EN to enable the rd_cnt/wr_cnt counters.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_LEN = 10,
    parameter int DATA_LEN = 1,
    parameter int SEL_LEN  = 2,
    parameter int RW_LEN   = 2,
    parameter int DEPTH    = 784,
    parameter int NBANK    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_LEN-1:0] addr,
    input  logic [SEL_LEN-1:0]  sel,
    input  logic [RW_LEN-1:0]   rw,
    input  logic [DATA_LEN-1:0] data_in,
    output logic [DATA_LEN-1:0] data_out,
    output logic                data_oe,
    output logic                rd_valid,
    output logic                err,
    input  logic                err_clr,
    output logic [15:0]         rd_cnt,
    output logic [15:0]         wr_cnt
);

    state_t              state_q, state_d;
    logic                hit_q, hit_d;
    logic [SEL_LEN-1:0]  rsel_q, rsel_d;
    logic                err_q, err_d;

    logic                in_range;
    logic                is_read, is_write, is_rsvd;
    logic                rd_hit, wr_commit, err_set;
    logic [DATA_LEN-1:0] bank_rdata [NBANK];
    logic [DATA_LEN-1:0] rdata_mux;

    assign in_range = (32'(addr) < 32'(DEPTH)) && (32'(sel) < 32'(NBANK));

    always_comb begin
        is_read  = 1'b0;
        is_write = 1'b0;
        is_rsvd  = 1'b0;
        case (rw)
            RW_LEN'(RW_IDLE):  ;
            RW_LEN'(RW_READ):  is_read  = 1'b1;
            RW_LEN'(RW_WRITE): is_write = 1'b1;
            RW_LEN'(RW_RSVD):  is_rsvd  = 1'b1;
            default:           is_rsvd  = 1'b1;
        endcase
    end

    // A write while we are driving the bus would collide with our own read data.
    assign rd_hit    = is_read && in_range;
    assign wr_commit = is_write && in_range && !data_oe;
    assign err_set   = (is_read && !in_range) || (is_write && (!in_range || data_oe)) || is_rsvd;

    always_comb begin
        state_d = is_read ? RESP : IDLE;
        hit_d   = rd_hit;
        rsel_d  = sel;
        err_d   = err_q;
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            hit_q   <= 1'b0;
            rsel_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            rsel_q  <= rsel_d;
            err_q   <= err_d;
        end
    end

    for (genvar i = 0; i < NBANK; i++) begin : g_bank
        mem_bank #(
            .ADDR_LEN (ADDR_LEN),
            .DATA_LEN (DATA_LEN),
            .DEPTH    (DEPTH)
        ) u_bank (
            .clk   (clk),
            .we    (wr_commit && (sel == SEL_LEN'(i))),
            .re    (rd_hit && (sel == SEL_LEN'(i))),
            .addr  (addr),
            .wdata (data_in),
            .rdata (bank_rdata[i])
        );
    end

    always_comb begin
        rdata_mux = '0;
        for (int i = 0; i < NBANK; i++) begin
            if (rsel_q == SEL_LEN'(i)) begin
                rdata_mux = bank_rdata[i];
            end
        end
    end

    // Bank read registers are not reset, so the output is masked by the reset-cleared state.
    assign rd_valid = (state_q == RESP);
    assign data_oe  = (state_q == RESP);
    assign data_out = (rd_valid && hit_q) ? rdata_mux : '0;
    assign err      = err_q;

`ifdef MEM_RESP_ACCESS_CNT_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (rd_hit && (rd_cnt_q != 16'hFFFF)) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
        if (wr_commit && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`else
    assign rd_cnt = 16'd0;
    assign wr_cnt = 16'd0;
`endif

endmodule
